ifetch_unit: RTL
================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage of the 32-bit MIPS core; directly upstream of decode.
//  Holds the PC and issues word reads to instruction memory over a valid/ready request port.
//  Buffers in-order responses in a DEPTH-entry FIFO and presents {instr, pc, pc+4} to decode.
//  Decode consumes them over a valid/ready handshake; id_op feeds the main decoder's op input.
//  Supports redirect (branch/jump target): flushes the FIFO and discards in-flight responses.
// PARAMETERS
//  n        32   address/PC width in bits
//  RESET_PC 0    PC value loaded on reset (word aligned)
//  DEPTH    2    instruction buffer entries; power of 2, >=2
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   memory accepts request this cycle
//  imem_addr      out  n   word-aligned fetch address (= current PC)
//  imem_rsp_valid in   1   read data valid; responses in request order, latency >=1 cycle
//  imem_rdata     in   32  instruction word
//  redirect       in   1   load new PC and flush this cycle
//  redirect_pc    in   n   new PC; bits [1:0] ignored (forced 2'b00)
//  id_valid       out  1   decode output valid (FIFO non-empty)
//  id_ready       in   1   decode accepts head entry
//  id_instr       out  32  head instruction
//  id_pc          out  n   PC of head instruction
//  id_pcplus4     out  n   id_pc + 4, modulo 2^n
//  id_op          out  6   id_instr[31:26]
// BEHAVIOUR
//  Reset (sync, active-high): pc<=RESET_PC; FIFO empty; outstanding<=0; drop<=0.
//   - While reset is high, all outputs are 0, including imem_req_valid.
//   - The first request may issue in the first cycle after reset deasserts.
//   - Reset mid-operation abandons every in-flight request.
//   - The environment guarantees no responses arrive for requests abandoned by reset.
//  Counters:
//   - outstanding = accepted requests whose responses have not yet returned; includes drops.
//   - live = outstanding - drop.
//  Request rule:
//   - imem_req_valid = (count + live - deq) < DEPTH, where deq = id_valid & id_ready.
//   - The rule does not depend on redirect.
//   - imem_addr = pc; addr is held stable while valid & !ready.
//  Accept (valid & ready):
//   - Allocate credit: outstanding+1.
//   - Record pc in an in-order PC queue (DEPTH entries).
//   - pc <= pc+4, wrapping modulo 2^n.
//  Response (imem_rsp_valid):
//   - If drop>0, discard it: drop-1, outstanding-1.
//   - Otherwise write {rdata, queued pc} to the FIFO tail: outstanding-1.
//   - The entry is visible on id_* the next cycle (min fetch-to-decode latency 2 cycles).
//  Dequeue (id_valid & id_ready): pop head.
//   - The head entry is stable while id_valid & !id_ready.
//   - Empty FIFO: id_valid=0 and id_instr/id_pc/id_pcplus4/id_op read 0.
//  Redirect (priority over every other update this cycle):
//   - pc <= {redirect_pc[n-1:2], 2'b00}.
//   - The FIFO is emptied.
//   - The PC queue is emptied.
//   - drop <= outstanding_next, counting a request accepted this same cycle.
//   - A response arriving in the redirect cycle is discarded.
//   - A dequeue in the redirect cycle still completes; decode owns that instruction.
//   - Back-to-back redirects: each one recomputes drop from the current outstanding count.
//  Throughput: 1 instruction/cycle sustained with 1-cycle memory and id_ready=1.
//  Overflow is impossible by construction; assert that count+live <= DEPTH every cycle.
//  Assert that no response is seen while outstanding==0.
// TESTING
//  1 Reset release, mem ready, 1-cycle latency, id_ready=1 -> addrs 0,4,8,...
//    one per cycle; id_pc 0,4,8 from cycle 2; id_pcplus4 = id_pc+4.
//  2 Backpressure: id_ready=0 from cycle 3 -> at most DEPTH entries buffered.
//    imem_req_valid drops; id_* held.
//    Release -> stream resumes with no skipped or duplicated PC.
//  3 Redirect to 0x0000_0103 with 2 requests in flight -> both responses discarded.
//    Next id_pc = 0x0000_0100; no pre-redirect instruction appears after flush.
//  4 imem_req_ready=0 for 5 cycles -> imem_addr stable, pc unchanged.
//  4 (cont.) imem_rdata=0x8C08_0004 -> id_op=6'b100011.
//  5 Reset asserted mid-stream with FIFO full -> next cycle id_valid=0, imem_req_valid=0.
//    After release, fetch restarts at RESET_PC.
//  6 Wrap: redirect to 0xFFFF_FFFC -> id_pc 0xFFFF_FFFC, then 0x0000_0000.
//    For the first entry, id_pcplus4=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word reads over a
// valid/ready request port, buffers returned words with their PCs in a small
// FIFO and hands {instr, pc, pc+4} to decode. A redirect reloads the PC,
// flushes both queues and marks every in-flight response for discard.
module ifetch_unit #(
    parameter int unsigned    n        = 32,
    parameter logic [n-1:0]   RESET_PC = '0,
    parameter int unsigned    DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [n-1:0]  imem_addr,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [n-1:0]  redirect_pc,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_instr,
    output logic [n-1:0]  id_pc,
    output logic [n-1:0]  id_pcplus4,
    output logic [5:0]    id_op
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Wide enough for dropped responses piling up behind repeated redirects.
    localparam int unsigned OW = 8;

    logic [n-1:0]  r_pc;
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [n-1:0]  r_fifo_pc    [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [n-1:0]  r_pq [DEPTH];
    logic [AW-1:0] r_pq_rd;
    logic [AW-1:0] r_pq_wr;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop;

    logic          w_acc;
    logic          w_deq;
    logic          w_rsp;
    logic          w_keep;
    logic [OW-1:0] w_live;
    logic [OW-1:0] w_occ_all;
    logic [OW-1:0] w_occ;
    logic [OW-1:0] w_out_next;
    logic [n-1:0]  w_redirect_pc;
    logic [n-1:0]  w_head_pc;

    assign w_redirect_pc = redirect_pc & ~n'(3);
    assign w_live        = r_outstanding - r_drop;
    assign w_occ_all     = OW'(r_count) + w_live;
    assign w_deq         = id_valid & id_ready;
    assign w_occ         = w_occ_all - OW'(w_deq);
    assign w_acc         = imem_req_valid & imem_req_ready;
    assign w_rsp         = imem_rsp_valid & ~reset;
    // Responses landing in a redirect cycle or owed to a drop never enter the FIFO.
    assign w_keep        = w_rsp & ~redirect & (r_drop == '0);
    assign w_out_next    = r_outstanding + OW'(w_acc) - OW'(w_rsp);

    assign imem_req_valid = ~reset & (w_occ < OW'(DEPTH));
    assign imem_addr      = reset ? '0 : r_pc;

    assign id_valid   = ~reset & (r_count != '0);
    assign w_head_pc  = r_fifo_pc[r_rd];
    assign id_instr   = id_valid ? r_fifo_instr[r_rd] : '0;
    assign id_pc      = id_valid ? w_head_pc : '0;
    assign id_pcplus4 = id_valid ? w_head_pc + n'(4) : '0;
    assign id_op      = id_instr[31:26];

    // PC, queue pointers, occupancy and credit/drop counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_rd          <= '0;
            r_wr          <= '0;
            r_count       <= '0;
            r_pq_rd       <= '0;
            r_pq_wr       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect) begin
                r_pc    <= w_redirect_pc;
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
                r_pq_rd <= '0;
                r_pq_wr <= '0;
                r_drop  <= w_out_next;
            end else begin
                if (w_acc) begin
                    r_pc    <= r_pc + n'(4);
                    r_pq_wr <= r_pq_wr + AW'(1);
                end
                if (w_rsp) begin
                    if (r_drop != '0) begin
                        r_drop <= r_drop - OW'(1);
                    end else begin
                        r_wr    <= r_wr + AW'(1);
                        r_pq_rd <= r_pq_rd + AW'(1);
                    end
                end
                if (w_deq) begin
                    r_rd <= r_rd + AW'(1);
                end
                r_count <= r_count + CW'(w_keep) - CW'(w_deq);
            end
        end
    end

    // Queue storage: PC of each accepted request, and returned instruction entries
    always_ff @(posedge clk) begin
        if (~reset & ~redirect & w_acc) begin
            r_pq[r_pq_wr] <= r_pc;
        end
        if (w_keep) begin
            r_fifo_instr[r_wr] <= imem_rdata;
            r_fifo_pc[r_wr]    <= r_pq[r_pq_rd];
        end
    end

    // Buffered plus live requests can never exceed the buffer size.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        w_occ_all <= OW'(DEPTH));

    // Memory must not answer a request that was never accepted.
    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (r_outstanding != '0));

endmodule
